inv_mix_column_seq: RTL and testbench

Sequential AES-128 InvMixColumns unit for the decryption datapath. It pairs with the combinational forward MixColumns stage used in encryption. The block accepts one 128-bit state over a valid/ready handshake and multiplies each column by the inverse constant matrix over GF(2^8). Columns are processed one per cycle, and the 128-bit result is presented over a second valid/ready handshake.

---
 rtl/inv_mix_column_seq.sv | 153 +++++++++++++++
 tb/tb_inv_mix_column_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_column_seq.sv
// Sequential AES-128 InvMixColumns, one column per cycle over valid/ready.
// Define INV_MIX_COL_PARALLEL_EN for the four-column, single-cycle variant.
`timescale 1ns/1ps
module inv_mix_column_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         girdi_gecerli,
   output logic         girdi_hazir,
   input  logic [127:0] girdi,
   output logic         cikti_gecerli,
   input  logic         cikti_hazir,
   output logic [127:0] cikti
);

   typedef enum logic [1:0] {
      BOS   = 2'd0,
      ISLE  = 2'd1,
      CIKIS = 2'd2
   } durum_t;

   durum_t       r_durum;
   durum_t       w_durum_sonraki;
   logic [127:0] r_girdi;
   logic [127:0] w_girdi_sonraki;
   logic [127:0] r_sonuc;
   logic [127:0] w_sonuc_sonraki;
   logic [1:0]   r_sutun;
   logic [1:0]   w_sutun_sonraki;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Packed as {x0e, x0b, x0d, x09} so the rotating rows index by slice.
   function automatic logic [31:0] carp(input logic [7:0] a);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return {x8 ^ x4 ^ x2,
              x8 ^ x2 ^ a,
              x8 ^ x4 ^ a,
              x8 ^ a};
   endfunction

   function automatic logic [31:0] ters_kolon(input logic [31:0] c);
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] p3;
      logic [7:0]  o0;
      logic [7:0]  o1;
      logic [7:0]  o2;
      logic [7:0]  o3;
      p0 = carp(c[31:24]);
      p1 = carp(c[23:16]);
      p2 = carp(c[15:8]);
      p3 = carp(c[7:0]);
      o0 = p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0];
      o1 = p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8];
      o2 = p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16];
      o3 = p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24];
      return {o0, o1, o2, o3};
   endfunction

`ifdef INV_MIX_COL_PARALLEL_EN
   logic [127:0] w_tam_sonuc;

   assign w_tam_sonuc = {ters_kolon(r_girdi[127:96]),
                         ters_kolon(r_girdi[95:64]),
                         ters_kolon(r_girdi[63:32]),
                         ters_kolon(r_girdi[31:0])};
`else
   logic [31:0] w_kolon_girdi;
   logic [31:0] w_kolon_cikti;

   always_comb begin
      w_kolon_girdi = r_girdi[127:96];
      unique case (r_sutun)
         2'd0: w_kolon_girdi = r_girdi[127:96];
         2'd1: w_kolon_girdi = r_girdi[95:64];
         2'd2: w_kolon_girdi = r_girdi[63:32];
         2'd3: w_kolon_girdi = r_girdi[31:0];
         default: w_kolon_girdi = r_girdi[127:96];
      endcase
   end

   assign w_kolon_cikti = ters_kolon(w_kolon_girdi);
`endif

   always_comb begin
      w_durum_sonraki = r_durum;
      w_girdi_sonraki = r_girdi;
      w_sonuc_sonraki = r_sonuc;
      w_sutun_sonraki = r_sutun;
      unique case (r_durum)
         BOS: begin
            if (girdi_gecerli) begin
               w_girdi_sonraki = girdi;
               w_sutun_sonraki = 2'd0;
               w_durum_sonraki = ISLE;
            end
         end
         ISLE: begin
`ifdef INV_MIX_COL_PARALLEL_EN
            w_sonuc_sonraki = w_tam_sonuc;
            w_sutun_sonraki = 2'd0;
            w_durum_sonraki = CIKIS;
`else
            unique case (r_sutun)
               2'd0: w_sonuc_sonraki[127:96] = w_kolon_cikti;
               2'd1: w_sonuc_sonraki[95:64]  = w_kolon_cikti;
               2'd2: w_sonuc_sonraki[63:32]  = w_kolon_cikti;
               2'd3: w_sonuc_sonraki[31:0]   = w_kolon_cikti;
               default: w_sonuc_sonraki = r_sonuc;
            endcase
            if (r_sutun == 2'd3) begin
               w_durum_sonraki = CIKIS;
            end else begin
               w_sutun_sonraki = r_sutun + 2'd1;
            end
`endif
         end
         CIKIS: begin
            if (cikti_hazir) begin
               w_durum_sonraki = BOS;
            end
         end
         default: w_durum_sonraki = BOS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_durum <= BOS;
         r_girdi <= '0;
         r_sonuc <= '0;
         r_sutun <= 2'd0;
      end else begin
         r_durum <= w_durum_sonraki;
         r_girdi <= w_girdi_sonraki;
         r_sonuc <= w_sonuc_sonraki;
         r_sutun <= w_sutun_sonraki;
      end
   end

   assign girdi_hazir   = (r_durum == BOS);
   assign cikti_gecerli = (r_durum == CIKIS);
   assign cikti         = r_sonuc;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Directed bench for inv_mix_column_seq: vectors, stalls, reset, round trip.
// Forward MixColumns model feeds the round-trip section.
`timescale 1ns/1ps
module tb_inv_mix_column_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         girdi_gecerli = 1'b0;
   logic         girdi_hazir;
   logic [127:0] girdi = '0;
   logic         cikti_gecerli;
   logic         cikti_hazir = 1'b0;
   logic [127:0] cikti;

   int errors = 0;
   int checks = 0;

`ifdef INV_MIX_COL_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 4;
`endif

   always #5 clk = ~clk;

   inv_mix_column_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .girdi_gecerli (girdi_gecerli),
      .girdi_hazir   (girdi_hazir),
      .girdi         (girdi),
      .cikti_gecerli (cikti_gecerli),
      .cikti_hazir   (cikti_hazir),
      .cikti         (cikti)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] fwd_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
              s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
              s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
              xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
   endfunction

   function automatic logic [127:0] fwd(input logic [127:0] x);
      return {fwd_col(x[127:96]), fwd_col(x[95:64]),
              fwd_col(x[63:32]), fwd_col(x[31:0])};
   endfunction

   task automatic run_block(input logic [127:0] d,
                            input logic [127:0] e,
                            input string tag);
      int n;
      girdi = d;
      girdi_gecerli = 1'b1;
      cikti_hazir = 1'b1;
      chk({tag, "_ready"}, girdi_hazir, 1'b1);
      step();
      girdi_gecerli = 1'b0;
      girdi = ~d;
      n = 0;
      while (!cikti_gecerli && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, LAT);
      chk({tag, "_data"}, cikti, e);
      step();
      chk({tag, "_valid_drop"}, cikti_gecerli, 1'b0);
      chk({tag, "_ready_back"}, girdi_hazir, 1'b1);
   endtask

   initial begin
      logic [127:0] x;
      logic [127:0] held;
      int n;
      int got;
      bit done;

      rst_n = 1'b0;
      step();
      step();
      chk("rst_cikti", cikti, 128'h0);
      chk("rst_valid", cikti_gecerli, 1'b0);
      chk("rst_ready", girdi_hazir, 1'b1);
      rst_n = 1'b1;
      step();

      run_block(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                128'hdb135345_f20a225c_01010101_c6c6c6c6, "known");
      run_block({16{8'h01}}, {16{8'h01}}, "ones");
      run_block({16{8'hc6}}, {16{8'hc6}}, "c6");
      run_block(128'h0, 128'h0, "zero");

      // Backpressure with a second request that must not be taken.
      cikti_hazir = 1'b0;
      girdi = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      girdi_gecerli = 1'b1;
      step();
      girdi = 128'h0123456789abcdef_0123456789abcdef;
      n = 0;
      while (!cikti_gecerli && n < 20) begin
         step();
         n++;
      end
      chk("bp_latency", n, LAT);
      held = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      for (int i = 0; i < 10; i++) begin
         chk("bp_data", cikti, held);
         chk("bp_valid", cikti_gecerli, 1'b1);
         chk("bp_ready", girdi_hazir, 1'b0);
         step();
      end
      girdi_gecerli = 1'b0;
      cikti_hazir = 1'b1;
      step();
      chk("bp_ready_back", girdi_hazir, 1'b1);
      chk("bp_valid_drop", cikti_gecerli, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("bp_no_extra", cikti_gecerli, 1'b0);
      end

      // Reset two edges after accept.
      cikti_hazir = 1'b0;
      girdi = {16{8'h5a}};
      girdi_gecerli = 1'b1;
      step();
      girdi_gecerli = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      chk("mrst_cikti", cikti, 128'h0);
      chk("mrst_valid", cikti_gecerli, 1'b0);
      chk("mrst_ready", girdi_hazir, 1'b1);
      rst_n = 1'b1;
      cikti_hazir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("mrst_no_valid", cikti_gecerli, 1'b0);
      end

      // Round trip through the forward model with random stalls.
      got = 0;
      for (int b = 0; b < 1000; b++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         cikti_hazir = 1'b0;
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
         girdi = fwd(x);
         girdi_gecerli = 1'b1;
         n = 0;
         while (!girdi_hazir && n < 20) begin
            step();
            n++;
         end
         step();
         girdi_gecerli = 1'b0;
         girdi = '0;
         done = 1'b0;
         for (int c = 0; c < 100 && !done; c++) begin
            cikti_hazir = 1'($urandom_range(0, 1));
            if (cikti_gecerli && cikti_hazir) begin
               chk("rt_data", cikti, x);
               got++;
               done = 1'b1;
            end
            step();
         end
         if (!done) chk("rt_timeout", 1'b0, 1'b1);
      end
      chk("rt_count", got, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
